// File: rtl/cic3_droop_comp.sv
// cic3_droop_comp
//   Droop-compensation FIR that sits after the 3rd-order CIC decimator. It
//   applies a fixed 5-tap symmetric kernel h = {-1,-2,38,-2,-1}/32, using one
//   time-multiplexed MAC. The result is rounded half-up and clamped to
//   [0, 2^NUMBITS-1].
//
//   Ports
//     clk        system clock (CIC modulator domain)
//     reset_n    synchronous active-low reset
//     in_data    unsigned CIC output sample
//     in_valid   sample strobe; transfer when in_valid & in_ready
//     in_ready   high while idle
//     bypass     skip filtering for this sample (sampled at acceptance)
//     out_data   compensated sample, held until the next result
//     out_valid  one-cycle pulse when out_data updates
//     overrun    sticky: a sample was offered while busy (and dropped)
//
//   Timing: accept edge 0, MAC on edges 1..5, result on edge 6.
//   The minimum accept spacing is therefore 7 clk.
module cic3_droop_comp #(
    parameter int NUMBITS = 25
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUMBITS-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               bypass,
    output logic [NUMBITS-1:0] out_data,
    output logic               out_valid,
    output logic               overrun
);

    // 38 * (2^NUMBITS-1) needs NUMBITS+6 magnitude bits. NUMBITS+9 leaves
    // headroom so the accumulator cannot wrap.
    localparam int AW = NUMBITS + 9;

    localparam logic signed [AW-1:0] RND  = {{(AW-5){1'b0}}, 5'd16};
    localparam logic signed [AW-1:0] OMAX = {{(AW-NUMBITS){1'b0}}, {NUMBITS{1'b1}}};

    typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

    state_t                    state_q, state_d;
    logic        [2:0]         idx_q, idx_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    logic        [NUMBITS-1:0] x_q [5];
    logic        [NUMBITS-1:0] x_d [5];
    logic                      byp_q, byp_d;
    logic        [NUMBITS-1:0] out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      ovr_q, ovr_d;

    // Tap select: coefficient and delay-line word for the current idx.
    logic signed [6:0]         coef;
    logic        [NUMBITS-1:0] xsel;
    logic signed [AW-1:0]      xs, cs, prod;
    logic signed [AW-1:0]      rnd_sum, shifted;
    logic        [NUMBITS-1:0] sat_val;

    always_comb begin
        coef = -7'sd1;
        xsel = x_q[0];
        case (idx_q)
            3'd0:    begin coef = -7'sd1; xsel = x_q[0]; end
            3'd1:    begin coef = -7'sd2; xsel = x_q[1]; end
            3'd2:    begin coef = 7'sd38; xsel = x_q[2]; end
            3'd3:    begin coef = -7'sd2; xsel = x_q[3]; end
            default: begin coef = -7'sd1; xsel = x_q[4]; end
        endcase
    end

    // Samples are zero-extended, so they are always non-negative in signed form.
    assign xs   = $signed({{(AW-NUMBITS){1'b0}}, xsel});
    assign cs   = $signed({{(AW-7){coef[6]}}, coef});
    assign prod = xs * cs;

    // Round half-up, then clamp into the unsigned output range.
    assign rnd_sum = acc_q + RND;
    assign shifted = rnd_sum >>> 5;

    always_comb begin
        if (shifted < 0)
            sat_val = '0;
        else if (shifted > OMAX)
            sat_val = {NUMBITS{1'b1}};
        else
            sat_val = shifted[NUMBITS-1:0];
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            for (int i = 0; i < 5; i++) x_q[i] <= '0;
            byp_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            byp_q       <= byp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MAC;
            MAC:     if (idx_q == 3'd4) state_d = SAT;
            SAT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        idx_d       = idx_q;
        acc_d       = acc_q;
        x_d         = x_q;
        byp_d       = byp_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        ovr_d       = ovr_q;

        // Offers while busy are dropped; only the sticky flag records them.
        if (in_valid && state_q != IDLE) ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // The delay line shifts even for bypassed samples.
                    x_d[4] = x_q[3];
                    x_d[3] = x_q[2];
                    x_d[2] = x_q[1];
                    x_d[1] = x_q[0];
                    x_d[0] = in_data;
                    byp_d  = bypass;
                    acc_d  = '0;
                    idx_d  = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + prod;
                idx_d = idx_q + 3'd1;
            end
            SAT: begin
                out_data_d  = byp_q ? x_q[0] : sat_val;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output logic.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_data  = out_data_q;
        out_valid = out_valid_q;
        overrun   = ovr_q;
    end

endmodule
